fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Program-counter / instruction-fetch stage feeding the Control decoder.
//  Holds the PC, drives the instruction-ROM address, and resolves branches
//  using Control's branch/branchEq/branchLT strobes and the ALU flags.
//  Halts on Control's done strobe. Reports run state and an executed-instruction count.
// PARAMETERS
//  PC_W     10  PC / ROM address width (bits)
//  LUT_IDX  5   branch-target LUT index width; instruction bits [LUT_IDX-1:0]
//  CNT_W    16  width of the instruction counter
// PORTS
//  CLK        in   1        clock; all state changes on rising edge
//  Reset_n    in   1        asynchronous, active-low reset
//  Start      in   1        level; while 1, forces PC=0 and state IDLE
//  Branch     in   1        unconditional branch (from Control)
//  BranchEq   in   1        branch if EqFlag (from Control)
//  BranchLT   in   1        branch if LtFlag (from Control)
//  Done       in   1        halt strobe (from Control)
//  EqFlag     in   1        equal flag from the seq result register
//  LtFlag     in   1        less-than flag from the slt result register
//  TargetIdx  in   LUT_IDX  branch-target LUT index (instruction immediate field)
//  PC         out  PC_W     current instruction address to the ROM
//  Running    out  1        1 in state RUN
//  Halted     out  1        1 in state HALT
//  InstCount  out  CNT_W    instructions retired since the last Start
// BEHAVIOUR
//  Reset (Reset_n=0, async): state=IDLE, PC=0, InstCount=0, Running=0, Halted=0.
//  FSM states: IDLE, RUN, HALT. Running and Halted are decoded from the state register.
//  Start=1 in any state: next state IDLE, PC<=0, InstCount<=0. Start has top priority.
//  IDLE & Start=0: next state RUN. PC stays 0. The first fetch happens in the RUN cycle.
//  In RUN, each cycle retires exactly one instruction; evaluate in this priority:
//   1 Done=1    -> state HALT, PC holds, InstCount+1
//   2 taken=1   -> PC <= LUT[TargetIdx] (zero-extended to PC_W), InstCount+1
//   3 otherwise -> PC <= PC+1, wrapping 2^PC_W-1 -> 0, InstCount+1
//  taken = Branch | (BranchEq & EqFlag) | (BranchLT & LtFlag).
//  Multiple branch strobes in one cycle: OR-combined; the target is the same LUT entry.
//  HALT: PC and InstCount frozen. Branch, Done and the flags are ignored. Leave HALT only via Start.
//  IDLE: all strobes are ignored and PC does not move.
//  InstCount saturates at all-ones; it never wraps.
//  Branch latency: the strobe in cycle n gives the new PC in cycle n+1. No delay slot.
//  Reset mid-RUN: returns to the reset values immediately, without waiting for a clock edge.
//  The LUT is a combinational constant table. Unlisted indices return 0.
// STRUCTURE
//  definitions package gains: fetch_state_t enum {IDLE, RUN, HALT}, PC_W default
//   constant, LUT_IDX default constant.
//  Sub-module branch_lut: input [LUT_IDX-1:0] idx, output [PC_W-1:0] target.
//   Combinational case-table; program-specific entries are edited only there.
//  fetch_unit holds: the state register, the PC register, the counter, and next-PC muxing.
// TESTING
//  1 Reset_n=0 while in RUN with PC=37 -> PC=0, Running=0, Halted=0, InstCount=0 at once.
//  2 Start 1->0, then 5 cycles with no strobes -> PC 0,1,2,3,4; InstCount=5.
//  3 LUT[3]=100, TargetIdx=3, BranchEq=1:
//     with EqFlag=0 -> PC+1; with EqFlag=1 -> PC=100 on the next cycle.
//  4 BranchLT=1, LtFlag=1 and Done=1 in the same cycle -> HALT, PC unchanged.
//     Then Branch=1 for 3 cycles -> PC and InstCount frozen.
//  5 PC=1023 (PC_W=10), no strobe -> PC=0. CNT_W=4 run past 15 -> InstCount stays 15.
//  6 In HALT, assert Start for 1 cycle, then release -> IDLE, PC=0, InstCount=0.
//     Then RUN on the following cycle.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage.
//   fetch_state_t : run state of the fetch FSM
//   *_DEF         : default widths for PC, branch-target LUT index, counter
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam int PC_W_DEF    = 10;
  localparam int LUT_IDX_DEF = 5;
  localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Branch-target lookup table. Combinational constant table; the
// program-specific entries live only here. Unlisted indices give 0.
// Ports:
//   idx    in  LUT_IDX  index taken from the instruction immediate field
//   target out PC_W     branch target address
module branch_lut
  import fetch_unit_pkg::*;
#(
  parameter int LUT_IDX = LUT_IDX_DEF,
  parameter int PC_W    = PC_W_DEF
) (
  input  logic [LUT_IDX-1:0] idx,
  output logic [PC_W-1:0]    target
);

  always_comb begin
    target = '0;
    case (idx)
      LUT_IDX'(1):  target = PC_W'(20);
      LUT_IDX'(2):  target = PC_W'(37);
      LUT_IDX'(3):  target = PC_W'(100);
      LUT_IDX'(7):  target = PC_W'(512);
      LUT_IDX'(31): target = PC_W'(1023);
      default:      target = '0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Program-counter / instruction-fetch stage. Holds the PC, drives the ROM
// address, resolves branches from Control's strobes and the ALU flags,
// halts on Done and counts retired instructions (saturating).
// Ports:
//   CLK        in   1        clock, rising edge
//   Reset_n    in   1        asynchronous active-low reset
//   Start      in   1        level; forces IDLE, PC=0, InstCount=0
//   Branch     in   1        unconditional branch
//   BranchEq   in   1        branch if EqFlag
//   BranchLT   in   1        branch if LtFlag
//   Done       in   1        halt strobe
//   EqFlag     in   1        equal flag
//   LtFlag     in   1        less-than flag
//   TargetIdx  in   LUT_IDX  branch-target LUT index
//   PC         out  PC_W     current instruction address
//   Running    out  1        state is RUN
//   Halted     out  1        state is HALT
//   InstCount  out  CNT_W    instructions retired since last Start
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int LUT_IDX = LUT_IDX_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               CLK,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic               Branch,
  input  logic               BranchEq,
  input  logic               BranchLT,
  input  logic               Done,
  input  logic               EqFlag,
  input  logic               LtFlag,
  input  logic [LUT_IDX-1:0] TargetIdx,
  output logic [PC_W-1:0]    PC,
  output logic               Running,
  output logic               Halted,
  output logic [CNT_W-1:0]   InstCount
);

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  lut_target;
  logic             taken;

  branch_lut #(
    .LUT_IDX (LUT_IDX),
    .PC_W    (PC_W)
  ) u_branch_lut (
    .idx    (TargetIdx),
    .target (lut_target)
  );

  // Multiple strobes simply OR together; they share one LUT entry.
  assign taken = Branch | (BranchEq & EqFlag) | (BranchLT & LtFlag);

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (Start) begin
      state_d = IDLE;
      pc_d    = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = RUN;
        RUN: begin
          // One instruction retires every RUN cycle, including the halting one.
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          if (Done)       state_d = HALT;
          else if (taken) pc_d = lut_target;
          else            pc_d = pc_q + PC_W'(1);  // wraps at 2^PC_W
        end
        HALT: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign PC        = pc_q;
  assign InstCount = cnt_q;
  assign Running   = (state_q == RUN);
  assign Halted    = (state_q == HALT);

endmodule
